// File: rtl/pll_rst_seq.sv
// pll_rst_seq: lock-qualified reset sequencer running on the free-running
// reference clock. Debounces the synchronized PLL lock, releases the
// per-domain resets one stage at a time, re-asserts them all on lock loss
// and keeps a saturating count of lock-loss events.
// Optional feature macro: PLL_RST_SEQ_TIMEOUT_EN. When defined, a WAIT_LOCK
// timeout pulses pll_rst for PLL_RST_CYCLES cycles. When undefined,
// pll_rst is tied low and WAIT_LOCK waits indefinitely.
module pll_rst_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int NUM_STAGES     = 4,
    parameter int STAGE_GAP      = 16,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int PLL_RST_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_lock,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] rst_stage,
    output logic                  ready,
    output logic [7:0]            lock_loss_cnt,
    output logic [2:0]            state
);

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared counter serves every state, so it is sized for the
    // largest value any state compares against.
    localparam int CNT_MAX = maxOf(maxOf(STABLE_CYCLES, STAGE_GAP),
                                   maxOf(TIMEOUT_CYCLES, PLL_RST_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = $clog2(NUM_STAGES) + 1;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        RESET_PLL = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       w_cnt_inc;

    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_nxt;

    logic [NUM_STAGES-1:0]  r_stage;
    logic [NUM_STAGES-1:0]  w_stage_nxt;

    logic                   r_ready;
    logic                   w_ready_nxt;

    logic [7:0]             r_loss;
    logic [7:0]             w_loss_nxt;

    logic                   w_stable_hit;
    logic                   w_gap_hit;
    logic                   w_all_cleared;

`ifdef PLL_RST_SEQ_TIMEOUT_EN
    logic                   r_pll_rst;
    logic                   w_pll_rst_nxt;
    logic                   w_timeout_hit;
    logic                   w_pll_done;
`endif

    // Bring the asynchronous lock into the reference-clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // Counter saturates instead of wrapping, which matters in an unbounded WAIT_LOCK.
    assign w_cnt_inc     = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_stable_hit  = (r_cnt == CNT_W'(STABLE_CYCLES - 1));
    assign w_gap_hit     = (r_cnt == CNT_W'(STAGE_GAP - 1));
    assign w_all_cleared = (r_idx == IDX_W'(NUM_STAGES));

`ifdef PLL_RST_SEQ_TIMEOUT_EN
    assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_pll_done    = (r_cnt == CNT_W'(PLL_RST_CYCLES - 1));
`endif

    // State register plus the registered outputs and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_stage <= '1;
            r_ready <= 1'b0;
            r_loss  <= '0;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
            r_pll_rst <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_stage <= w_stage_nxt;
            r_ready <= w_ready_nxt;
            r_loss  <= w_loss_nxt;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
            r_pll_rst <= w_pll_rst_nxt;
`endif
        end
    end

    // Next-state decision from the synchronized lock and the counter compares.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = STABLE;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
                end else if (w_timeout_hit) begin
                    w_state_nxt = RESET_PLL;
`endif
                end
            end
            STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (w_stable_hit) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (w_gap_hit && w_all_cleared) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                end
            end
`ifdef PLL_RST_SEQ_TIMEOUT_EN
            RESET_PLL: begin
                if (w_pll_done) begin
                    w_state_nxt = WAIT_LOCK;
                end
            end
`endif
            default: begin
                w_state_nxt = WAIT_LOCK;
            end
        endcase
    end

    // Next values of counters and outputs; stages clear strictly in index order.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_stage_nxt = r_stage;
        w_ready_nxt = r_ready;
        w_loss_nxt  = r_loss;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
        w_pll_rst_nxt = 1'b0;
`endif
        case (r_state)
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_cnt_nxt = '0;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
                end else if (w_timeout_hit) begin
                    w_cnt_nxt     = '0;
                    w_pll_rst_nxt = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            STABLE: begin
                if (!w_lock_s) begin
                    w_cnt_nxt = '0;
                end else if (w_stable_hit) begin
                    w_cnt_nxt      = '0;
                    w_stage_nxt[0] = 1'b0;
                    w_idx_nxt      = IDX_W'(1);
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            RELEASE, RUN: begin
                if (!w_lock_s) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_stage_nxt = '1;
                    w_ready_nxt = 1'b0;
                    w_loss_nxt  = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
                end else if (r_state == RELEASE) begin
                    if (w_gap_hit) begin
                        w_cnt_nxt = '0;
                        if (w_all_cleared) begin
                            w_ready_nxt = 1'b1;
                        end else begin
                            for (int k = 0; k < NUM_STAGES; k++) begin
                                if (r_idx == IDX_W'(k)) begin
                                    w_stage_nxt[k] = 1'b0;
                                end
                            end
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
`ifdef PLL_RST_SEQ_TIMEOUT_EN
            RESET_PLL: begin
                if (w_pll_done) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt     = w_cnt_inc;
                    w_pll_rst_nxt = 1'b1;
                end
            end
`endif
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    assign rst_stage     = r_stage;
    assign ready         = r_ready;
    assign lock_loss_cnt = r_loss;
    assign state         = r_state;

`ifdef PLL_RST_SEQ_TIMEOUT_EN
    assign pll_rst = r_pll_rst;
`else
    assign pll_rst = 1'b0;
`endif

endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

Lock-qualified reset sequencer that consumes the PLL `pll_lock` output and produces staged, per-domain reset requests for the video/PCIe/Ethernet logic clocked by the PLL outputs. It runs on the free-running board reference clock (50 MHz), not on a PLL output, so it keeps operating while the PLL is unlocked. It debounces lock, releases the resets one stage at a time, re-asserts all of them on lock loss and counts those events. Optionally it pulses the PLL reset when lock is not reached within a timeout.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `pll_lock` (≥2).
- `STABLE_CYCLES`, 1024: number of consecutive synchronized-lock cycles required before release starts.
- `NUM_STAGES`, 4: number of reset outputs.
- `STAGE_GAP`, 16: cycles between successive stage releases.
- `TIMEOUT_CYCLES`, 500000: WAIT_LOCK timeout, 10 ms at 50 MHz.
- `PLL_RST_CYCLES`, 64: width of the `pll_rst` pulse.

Ports:
- `clk` in 1: free-running 50 MHz reference clock, the same source as the PLL `clkin1`.
- `rst` in 1: asynchronous, active-high reset.
- `pll_lock` in 1: PLL lock, asynchronous to `clk`.
- `pll_rst` out 1: active-high PLL reset request.
- `rst_stage` out NUM_STAGES: active-high reset per consumer. Each consumer resynchronizes it into its own domain.
- `ready` out 1: all stages released and lock held.
- `lock_loss_cnt` out 8: saturating count of lock losses.
- `state` out 3: current FSM state, for debug.

## Operation
Reset values: `rst_stage`=all ones, `pll_rst`=0, `ready`=0, `lock_loss_cnt`=0, `state`=WAIT_LOCK, counters=0.

`pll_lock` passes through a SYNC_STAGES flop chain, producing `lock_s`. Everything below uses `lock_s` only.

State encodings: WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3, RESET_PLL=4.

- **WAIT_LOCK:**
  - `lock_s`=1 → STABLE, cnt=0.
  - Otherwise cnt increments. With the macro, cnt==TIMEOUT_CYCLES-1 → RESET_PLL, cnt=0.
- **STABLE:**
  - `lock_s`=0 → WAIT_LOCK, cnt=0. This is not counted as a loss.
  - cnt==STABLE_CYCLES-1 → RELEASE. On the same edge `rst_stage[0]` is cleared and cnt=0.
- **RELEASE:**
  - cnt increments. Each time cnt reaches STAGE_GAP-1, the next stage is cleared and cnt=0.
  - STAGE_GAP cycles after the last stage is cleared → RUN, and `ready` is set on that edge.
  - NUM_STAGES=1 is legal: only the RUN delay applies.
- **RUN:** holds until lock loss.
- **Lock loss** (`lock_s`=0 in RELEASE or RUN), on a single edge:
  - `rst_stage` is set to all ones and `ready` is cleared.
  - `lock_loss_cnt` increments, saturating at 255.
  - State → WAIT_LOCK, cnt=0.
- **RESET_PLL:**
  - `pll_rst`=1 for exactly PLL_RST_CYCLES cycles, then `pll_rst`=0 → WAIT_LOCK with cnt=0.
  - `lock_s` is ignored in this state.
- `rst_stage` bits clear only in increasing index order. Once cleared, a bit stays low until a lock loss or `rst`.
- `rst` asserted mid-operation returns every output to its reset value immediately (asynchronously).
- Counter widths are `$clog2` of the largest compared value plus 1. No counter wraps.

## Timing
- Let S be the first `clk` edge at which `pll_lock` is sampled high, with lock held afterwards. Then:
  - `rst_stage[0]` falls at edge S+SYNC_STAGES+STABLE_CYCLES.
  - `rst_stage[k]` falls k·STAGE_GAP edges after `rst_stage[0]`.
  - `ready` rises NUM_STAGES·STAGE_GAP edges after `rst_stage[0]`.
- Lock loss: `pll_lock` sampled low at edge L → `rst_stage` all ones and `ready` low at edge L+SYNC_STAGES.
- A lock glitch shorter than one `clk` period can be missed. That is acceptable because the PLL lock is level-stable.
- `pll_rst` is registered, so it carries no combinational path from any input.

## Configuration
- `PLL_RST_SEQ_TIMEOUT_EN` defined: the WAIT_LOCK timeout and the RESET_PLL state are compiled in.
- Undefined: RESET_PLL is removed, `pll_rst` is tied to 0 and WAIT_LOCK waits indefinitely. All other behaviour is identical.

## Test plan
Benches use SYNC_STAGES=2, STABLE_CYCLES=8, NUM_STAGES=3, STAGE_GAP=4, TIMEOUT_CYCLES=100, PLL_RST_CYCLES=5 unless stated.
- Clean lock: `pll_lock` high before edge 0 → `rst_stage` bits fall at edges 10, 14, 18; `ready` rises at edge 22; `lock_loss_cnt`=0.
- Glitch during STABLE: lock high for 5 cycles, low for 1, then high → no `rst_stage` bit clears until 8 stable cycles after relock; `lock_loss_cnt` stays 0.
- Loss in RUN: drop `pll_lock` at edge L → `rst_stage`=3'b111 and `ready`=0 at L+2; `lock_loss_cnt`=1; on relock the full release sequence repeats.
- Saturation: 260 loss/relock cycles → `lock_loss_cnt`=255.
- Timeout (macro defined): `pll_lock` held low → `pll_rst` high for exactly 5 cycles starting 100 cycles after reset, repeating every 105 cycles. With the macro undefined, `pll_rst` never asserts.
- Async reset mid-RELEASE: assert `rst` after `rst_stage[0]` clears → all outputs return to reset values immediately, without waiting for a `clk` edge; the sequence restarts cleanly after `rst` is released.
